// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_mux
// Description : Time-multiplexed scanner for an NDIGITS common-anode
//               7-segment display. Rotates one digit per PRESCALE-cycle slot,
//               drives active-low anodes with an anti-ghosting guard at the
//               end of each slot, and double-buffers new values so they are
//               only applied on frame boundaries.
//               Optional feature macro: LEADING_ZERO_BLANK_EN
//               (when defined, leading zero digits above digit 0 are blanked).
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_mux #(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  output logic [3:0]             digit,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame,
  output logic                   load_ack
);

  // Counter and index widths; both parameters are at least 2.
  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(NDIGITS);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NDIGITS - 1);
  // One bit wider so that GUARD==0 (on-time == PRESCALE) still fits.
  localparam logic [CNT_W:0]   c_cnt_on   = (CNT_W + 1)'(PRESCALE - GUARD);

  // Registered state
  logic [CNT_W-1:0]       cnt_q,      cnt_d;
  logic [IDX_W-1:0]       idx_q,      idx_d;
  logic [4*NDIGITS-1:0]   shadow_q,   shadow_d;
  logic [4*NDIGITS-1:0]   pending_q,  pending_d;
  logic                   pend_vld_q, pend_vld_d;
  logic                   ack_q,      ack_d;

  // Combinational helpers
  logic                   w_tick;
  logic                   w_wrap;
  logic                   w_lit;
  logic [NDIGITS-1:0]     w_blank;

  assign w_tick = (cnt_q == c_cnt_last);
  assign w_wrap = w_tick && (idx_q == c_idx_last);
  // Anode may be on only before the guard interval at the end of the slot.
  assign w_lit  = ({1'b0, cnt_q} < c_cnt_on);

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above digit 0 is blanked when it and all higher digits are zero.
  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_lzb
    if (gi == 0) begin : g_digit0
      assign w_blank[gi] = 1'b0;
    end else begin : g_upper
      assign w_blank[gi] = (shadow_q[4*NDIGITS-1:4*gi] == '0);
    end
  end
`else
  assign w_blank = '0;
`endif

  // Next-state: prescaler, slot index and double-buffered load staging.
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;

    if (w_tick) begin
      cnt_d = '0;
      if (idx_q == c_idx_last) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // A load arriving exactly at the wrap goes straight to the display and
    // supersedes anything still pending.
    if (w_wrap && load) begin
      shadow_d   = value;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end else if (w_wrap && pend_vld_q) begin
      shadow_d   = pending_q;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end else if (!w_wrap && load) begin
      pending_d  = value;
      pend_vld_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
    end
  end

  // Output decode; everything is forced idle while reset is asserted so the
  // first released cycle already shows slot 0 with the frame marker.
  always_comb begin
    an       = '1;
    digit    = 4'h0;
    frame    = 1'b0;
    load_ack = 1'b0;
    if (reset_n) begin
      digit    = shadow_q[{idx_q, 2'b00} +: 4];
      frame    = (idx_q == '0) && (cnt_q == '0);
      load_ack = ack_q;
      if (w_lit && !w_blank[idx_q]) begin
        an[idx_q] = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
